bpu: RTL and testbench

BPU -- requirements
Module: bpu

---
 rtl/bpu_pkg.sv | 30 +++
 rtl/bpu_sat_counter2.sv | 22 ++
 rtl/bpu.sv | 141 ++++++++++++++
 tb/tb_bpu.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared definitions for the branch prediction unit: jump-type bit positions,
// default table depth and 2-bit counter encodings.
package bpu_pkg;

  localparam int unsigned ENTRIES_DEF = 16;

  // Bit positions inside the one-hot upd_jump_type vector
  localparam int unsigned JT_JAL  = 0;
  localparam int unsigned JT_JALR = 1;
  localparam int unsigned JT_BEQ  = 2;
  localparam int unsigned JT_BNE  = 3;
  localparam int unsigned JT_BLT  = 4;
  localparam int unsigned JT_BGE  = 5;
  localparam int unsigned JT_BLTU = 6;
  localparam int unsigned JT_BGEU = 7;
  localparam int unsigned JT_W    = 8;

  typedef enum logic [1:0] {
    CTR_SNT = 2'd0,
    CTR_WNT = 2'd1,
    CTR_WT  = 2'd2,
    CTR_ST  = 2'd3
  } ctr_e;

  // Exactly one bit set; all-zero and multi-hot encodings are illegal
  function automatic logic is_onehot8(input logic [JT_W-1:0] v);
    return (v != '0) && ((v & (v - 8'd1)) == '0);
  endfunction

endpackage

// File: rtl/bpu_sat_counter2.sv
// 2-bit saturating up/down counter next-state function.
module sat_counter2
  import bpu_pkg::*;
(
  input  ctr_e ctr_i,
  input  logic taken_i,
  output ctr_e ctr_o
);

  // Step toward strongly-taken on taken, toward strongly-not-taken otherwise
  always_comb begin
    ctr_o = ctr_i;
    unique case (ctr_i)
      CTR_SNT: ctr_o = taken_i ? CTR_WNT : CTR_SNT;
      CTR_WNT: ctr_o = taken_i ? CTR_WT  : CTR_SNT;
      CTR_WT:  ctr_o = taken_i ? CTR_ST  : CTR_WNT;
      CTR_ST:  ctr_o = taken_i ? CTR_ST  : CTR_WT;
      default: ctr_o = ctr_i;
    endcase
  end

endmodule

// File: rtl/bpu.sv
// Direct-mapped BTB/BHT branch predictor with resolution-side redirect and
// event counters. Lookup is combinational from registered tables; updates are
// written on the clock edge and become visible the following cycle.
module bpu
  import bpu_pkg::*;
#(
  parameter int unsigned ENTRIES = ENTRIES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [7:0]  upd_jump_type,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int unsigned IW = $clog2(ENTRIES);
  localparam int unsigned TW = 30 - IW;

  // Table storage (flops, one read port for fetch, one write port for update)
  logic          valid_q [ENTRIES];
  logic [TW-1:0] tag_q   [ENTRIES];
  logic [31:0]   tgt_q   [ENTRIES];
  ctr_e          ctr_q   [ENTRIES];
  logic          unc_q   [ENTRIES];

  logic [31:0] br_q, mp_q;

  logic [IW-1:0] f_idx, u_idx;
  logic [TW-1:0] f_tag, u_tag;
  logic          f_hit, u_hit;
  logic          legal, is_unc;

  logic          wr_en;
  logic [31:0]   ent_tgt_d;
  ctr_e          ent_ctr_d;
  logic          ent_unc_d;
  ctr_e          ctr_nxt;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

  assign f_idx = fetch_pc[IW+1:2];
  assign f_tag = fetch_pc[31:IW+2];
  assign u_idx = upd_pc[IW+1:2];
  assign u_tag = upd_pc[31:IW+2];

  assign legal  = upd_valid & is_onehot8(upd_jump_type);
  assign is_unc = upd_jump_type[JT_JAL] | upd_jump_type[JT_JALR];

  // Fetch-side lookup
  always_comb begin
    f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken  = f_hit && (unc_q[f_idx] || ctr_q[f_idx][1]);
    pred_target = pred_taken ? tgt_q[f_idx] : fetch_pc + 32'd4;
  end

  // Resolution-side redirect, independent of table state
  always_comb begin
    redirect    = legal && ((upd_taken != upd_pred_taken) ||
                            (upd_taken && (upd_target != upd_pred_target)));
    redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;
  end

  sat_counter2 u_ctr (
    .ctr_i   (ctr_q[u_idx]),
    .taken_i (upd_taken),
    .ctr_o   (ctr_nxt)
  );

  // Decide whether and what to write into the update-indexed entry
  always_comb begin
    u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    wr_en     = 1'b0;
    ent_tgt_d = tgt_q[u_idx];
    ent_ctr_d = ctr_q[u_idx];
    ent_unc_d = unc_q[u_idx];
    if (legal) begin
      if (u_hit) begin
        wr_en = 1'b1;
        if (is_unc) begin
          ent_unc_d = 1'b1;
          ent_ctr_d = CTR_ST;
          ent_tgt_d = upd_target;
        end else begin
          ent_ctr_d = ctr_nxt;
          if (upd_taken) ent_tgt_d = upd_target;
        end
      end else if (upd_taken) begin
        wr_en     = 1'b1;
        ent_tgt_d = upd_target;
        ent_unc_d = is_unc;
        ent_ctr_d = is_unc ? CTR_ST : CTR_WT;
      end
    end
  end

  // Table write port; reset clears every entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_WNT;
        unc_q[i]   <= 1'b0;
      end
    end else if (wr_en) begin
      valid_q[u_idx] <= 1'b1;
      tag_q[u_idx]   <= u_tag;
      tgt_q[u_idx]   <= ent_tgt_d;
      ctr_q[u_idx]   <= ent_ctr_d;
      unc_q[u_idx]   <= ent_unc_d;
    end
  end

  // Saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      if (legal && (br_q != '1)) br_q <= br_q + 32'd1;
      if (redirect && (mp_q != '1)) mp_q <= mp_q + 32'd1;
    end
  end

  assign stat_branches    = br_q;
  assign stat_mispredicts = mp_q;

endmodule

// File: tb/tb_bpu.sv
// Directed scoreboard bench for bpu: each stimulus cycle pushes its expected
// outputs, a monitor pops and compares them on the falling edge.
module tb_bpu;

  localparam logic [7:0] JAL  = 8'h01;
  localparam logic [7:0] BEQ  = 8'h04;
  localparam logic [7:0] BNE  = 8'h08;
  localparam logic [7:0] BLT  = 8'h10;
  localparam logic [7:0] BGEU = 8'h80;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic [7:0]  upd_jump_type = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_pred_taken = 1'b0;
  logic [31:0] upd_pred_target = '0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches, stat_mispredicts;

  bpu #(.ENTRIES(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_pc         (fetch_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_jump_type    (upd_jump_type),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_pred_target  (upd_pred_target),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic        e_rd;
    logic [31:0] e_rpc;
    logic [31:0] e_br;
    logic [31:0] e_mp;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vid   = 0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL vec%0d %s: got %h expected %h", id, nm, act, exp);
    end
  endtask

  // Monitor: compare one expectation per cycle on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("pred_taken",       e.id, {31'd0, pred_taken}, {31'd0, e.e_pt});
        chk("pred_target",      e.id, pred_target,         e.e_ptgt);
        chk("redirect",         e.id, {31'd0, redirect},   {31'd0, e.e_rd});
        chk("redirect_pc",      e.id, redirect_pc,         e.e_rpc);
        chk("stat_branches",    e.id, stat_branches,       e.e_br);
        chk("stat_mispredicts", e.id, stat_mispredicts,    e.e_mp);
      end
    end
  end

  task automatic step(
    input logic rst, input logic [31:0] fpc,
    input logic uv, input logic [31:0] pc, input logic [7:0] jt,
    input logic tk, input logic [31:0] tgt, input logic ppt, input logic [31:0] pptgt,
    input logic e_pt, input logic [31:0] e_ptgt,
    input logic e_rd, input logic [31:0] e_rpc,
    input logic [31:0] e_br, input logic [31:0] e_mp);
    exp_t e;
    rst_n           = rst;
    fetch_pc        = fpc;
    upd_valid       = uv;
    upd_pc          = pc;
    upd_jump_type   = jt;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ppt;
    upd_pred_target = pptgt;
    e.id = vid; e.e_pt = e_pt; e.e_ptgt = e_ptgt; e.e_rd = e_rd;
    e.e_rpc = e_rpc; e.e_br = e_br; e.e_mp = e_mp;
    q.push_back(e);
    vid++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    //   rst fetch        uv pc           jt    tk tgt          ppt pptgt        pt ptgt         rd rpc          br    mp
    // 0: in reset, lookup idle, redirect still driven by update inputs
    step(0, 32'h80000000, 1, 32'h80000010, BNE,  1, 32'h80000040, 0, 32'h80000014, 0, 32'h80000004, 1, 32'h80000040, 32'd0, 32'd0);
    // 1: bne miss taken -> allocate, redirect
    step(1, 32'h80000010, 1, 32'h80000010, BNE,  1, 32'h80000040, 0, 32'h80000014, 0, 32'h80000014, 1, 32'h80000040, 32'd0, 32'd0);
    // 2: lookup hits (ctr=2); same-cycle not-taken update sees old entry
    step(1, 32'h80000010, 1, 32'h80000010, BNE,  0, 32'h80000040, 1, 32'h80000040, 1, 32'h80000040, 1, 32'h80000014, 32'd1, 32'd1);
    // 3: ctr=1 -> not taken; second not-taken
    step(1, 32'h80000010, 1, 32'h80000010, BNE,  0, 32'h80000040, 0, 32'h80000014, 0, 32'h80000014, 0, 32'h80000014, 32'd2, 32'd2);
    // 4: ctr=0; jal at 0x80000020 allocates idx 8
    step(1, 32'h80000010, 1, 32'h80000020, JAL,  1, 32'h80000100, 0, 32'h80000024, 0, 32'h80000014, 1, 32'h80000100, 32'd3, 32'd2);
    // 5: jal hit; conflicting blt at 0x80000060 replaces idx 8
    step(1, 32'h80000020, 1, 32'h80000060, BLT,  1, 32'h80000200, 0, 32'h80000064, 1, 32'h80000100, 1, 32'h80000200, 32'd4, 32'd3);
    // 6: 0x80000020 now misses; multi-hot type ignored
    step(1, 32'h80000020, 1, 32'h80000030, 8'h0C, 1, 32'h80000400, 0, 32'h80000034, 0, 32'h80000024, 0, 32'h80000400, 32'd5, 32'd4);
    // 7: replacement entry hits; all-zero type ignored
    step(1, 32'h80000060, 1, 32'h80000030, 8'h00, 0, 32'h80000400, 1, 32'h80000400, 1, 32'h80000200, 0, 32'h80000034, 32'd5, 32'd4);
    // 8: taken with wrong predicted target -> redirect, target overwritten
    step(1, 32'h80000060, 1, 32'h80000060, BGEU, 1, 32'h80000300, 1, 32'h80000200, 1, 32'h80000200, 1, 32'h80000300, 32'd5, 32'd4);
    // 9: new target visible; not-taken at top of address space wraps
    step(1, 32'h80000060, 1, 32'hFFFFFFFC, BEQ,  0, 32'h00001000, 0, 32'h00000000, 1, 32'h80000300, 0, 32'h00000000, 32'd6, 32'd5);
    // 10: fetch fall-through wraps; jal hits conditional entry
    step(1, 32'hFFFFFFFC, 1, 32'h80000010, JAL,  1, 32'h80000080, 0, 32'h80000014, 0, 32'h00000000, 1, 32'h80000080, 32'd7, 32'd5);
    // 11: entry now unconditional to 0x80000080; idle update
    step(1, 32'h80000010, 0, 32'h80000000, BNE,  0, 32'h80000040, 1, 32'h80000040, 1, 32'h80000080, 0, 32'h80000004, 32'd8, 32'd6);
    // 12: reset mid-burst clears tables and counters immediately
    step(0, 32'h80000010, 1, 32'h80000010, BNE,  1, 32'h80000040, 0, 32'h80000014, 0, 32'h80000014, 1, 32'h80000040, 32'd0, 32'd0);
    // 13: first update after release is accepted
    step(1, 32'h80000010, 1, 32'h80000010, BNE,  1, 32'h80000040, 0, 32'h80000014, 0, 32'h80000014, 1, 32'h80000040, 32'd0, 32'd0);
    // 14: it counts once and the entry is allocated
    step(1, 32'h80000010, 0, 32'h80000010, BNE,  0, 32'h80000040, 0, 32'h80000014, 1, 32'h80000040, 0, 32'h80000014, 32'd1, 32'd1);

    repeat (3) @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
